// File: rtl/fir5_tap.sv
// 5-tap unsigned FIR with run-time loaded coefficients, sequenced by a load/sample protocol FSM.
// One-cycle latency from an accepted sample to data_out/out_enable; protocol violations latch error until reset.
module fir5_tap #(
  parameter int TAPS = 5,
  parameter int DW   = 8,
  parameter int OW   = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] data_in,
  input  logic          coef_enable,
  input  logic          sample_enable,
  output logic [OW-1:0] data_out,
  output logic          out_enable,
  output logic          error
);

  localparam int PW = 2 * DW;
  localparam int AW = PW + 3;
  localparam int CW = 3;
  localparam int SW = 8;
  localparam logic [CW-1:0] LAST_COEF = CW'(TAPS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COEF  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [TAPS-1:0][DW-1:0]   coef_q, coef_d;
  logic [TAPS-1:0][DW-1:0]   hist_q, hist_d;
  logic [CW-1:0]             cnt_coef_q, cnt_coef_d;
  logic [SW-1:0]             cnt_samp_q, cnt_samp_d;
  logic [OW-1:0]             dout_q, dout_d;
  logic                      oen_q, oen_d;
  logic                      err_q, err_d;

  // tap_x[0] is the incoming sample; tap_x[i] is the pre-shift history x(i-1).
  logic [TAPS-1:0][DW-1:0]   tap_x;
  logic [PW-1:0]             prod;
  logic [AW-1:0]             acc;
  logic                      accept;

  assign tap_x = {hist_q[TAPS-2:0], data_in};

  always_comb begin
    prod = '0;
    acc  = '0;
    for (int i = 0; i < TAPS; i++) begin
      prod = {{DW{1'b0}}, coef_q[i]} * {{DW{1'b0}}, tap_x[i]};
      acc  = acc + {{(AW-PW){1'b0}}, prod};
    end
  end

  always_comb begin
    state_d    = state_q;
    coef_d     = coef_q;
    hist_d     = hist_q;
    cnt_coef_d = cnt_coef_q;
    cnt_samp_d = cnt_samp_q;
    dout_d     = dout_q;
    oen_d      = 1'b0;
    err_d      = err_q;
    accept     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sample_enable) begin
          state_d = ST_ERR;
        end else if (coef_enable) begin
          hist_d     = '0;
          coef_d[0]  = data_in;
          cnt_coef_d = CW'(1);
          state_d    = ST_COEF;
        end
      end

      ST_COEF: begin
        if (coef_enable && sample_enable) begin
          state_d = ST_ERR;
        end else if (coef_enable) begin
          if (cnt_coef_q == LAST_COEF) begin
            state_d = ST_ERR;
          end else begin
            coef_d[cnt_coef_q] = data_in;
            cnt_coef_d         = cnt_coef_q + CW'(1);
          end
        end else if (cnt_coef_q == LAST_COEF) begin
          // A sample arriving on the load-complete edge is filtered immediately.
          state_d = ST_READY;
          accept  = sample_enable;
        end else begin
          state_d = ST_ERR;
        end
      end

      ST_READY: begin
        if (coef_enable && sample_enable) begin
          state_d = ST_ERR;
        end else if (sample_enable) begin
          accept = 1'b1;
        end else if (coef_enable) begin
          hist_d     = '0;
          coef_d[0]  = data_in;
          cnt_coef_d = CW'(1);
          state_d    = ST_COEF;
        end
      end

      default: begin
        state_d = ST_ERR;
      end
    endcase

    if (accept) begin
      hist_d     = tap_x;
      dout_d     = acc[OW-1:0];
      oen_d      = 1'b1;
      cnt_samp_d = cnt_samp_q + SW'(1);
    end

    if (state_d == ST_ERR) begin
      err_d = 1'b1;
      oen_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      coef_q     <= '0;
      hist_q     <= '0;
      cnt_coef_q <= '0;
      cnt_samp_q <= '0;
      dout_q     <= '0;
      oen_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      coef_q     <= coef_d;
      hist_q     <= hist_d;
      cnt_coef_q <= cnt_coef_d;
      cnt_samp_q <= cnt_samp_d;
      dout_q     <= dout_d;
      oen_q      <= oen_d;
      err_q      <= err_d;
    end
  end

  assign data_out   = dout_q;
  assign out_enable = oen_q;
  assign error      = err_q;

  // Oldest history slot and accumulator guard bits are kept but never feed an output.
  logic unused_bits;
  assign unused_bits = ^{hist_q[TAPS-1], acc[AW-1:OW], cnt_samp_q};

endmodule

// File: tb/tb_fir5_tap.sv
// Directed bench for fir5_tap: a small reference model pushes expected outputs to a
// scoreboard queue when a sample is driven; they are popped when out_enable strobes.
module tb_fir5_tap;

  logic        clk;
  logic        reset;
  logic [7:0]  data_in;
  logic        coef_enable;
  logic        sample_enable;
  logic [15:0] data_out;
  logic        out_enable;
  logic        error;

  fir5_tap dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .coef_enable   (coef_enable),
    .sample_enable (sample_enable),
    .data_out      (data_out),
    .out_enable    (out_enable),
    .error         (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] sb[$];
  logic [7:0]  mc[5];
  logic [7:0]  mx[5];
  logic [15:0] last_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_fir(input logic [7:0] d);
    int s;
    s = int'(mc[0]) * int'(d);
    for (int i = 1; i < 5; i++) s += int'(mc[i]) * int'(mx[i-1]);
    return 16'(s);
  endfunction

  function automatic void model_shift(input logic [7:0] d);
    for (int i = 4; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = d;
  endfunction

  // One clock: drive at negedge, check just after the following posedge.
  task automatic step(input logic ce, input logic se, input logic [7:0] d,
                      input logic exp_acc, input logic exp_err);
    @(negedge clk);
    coef_enable   = ce;
    sample_enable = se;
    data_in       = d;
    if (exp_acc) begin
      sb.push_back(model_fir(d));
      model_shift(d);
    end
    @(posedge clk);
    #1;
    chk("out_enable", 32'(out_enable), 32'(exp_acc));
    chk("error", 32'(error), 32'(exp_err));
    if (out_enable === 1'b1) begin
      chk("sb_pending", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        last_out = sb.pop_front();
        chk("data_out", 32'(data_out), 32'(last_out));
      end
    end else begin
      chk("data_out_hold", 32'(data_out), 32'(last_out));
    end
  endtask

  task automatic load(input logic [7:0] c0, c1, c2, c3, c4);
    mc[0] = c0; mc[1] = c1; mc[2] = c2; mc[3] = c3; mc[4] = c4;
    for (int i = 0; i < 5; i++) mx[i] = 8'd0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, mc[i], 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_out_enable", 32'(out_enable), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    sb.delete();
    last_out = 16'd0;
    for (int i = 0; i < 5; i++) begin
      mc[i] = 8'd0;
      mx[i] = 8'd0;
    end
    @(negedge clk);
    coef_enable   = 1'b0;
    sample_enable = 1'b0;
    data_in       = 8'd0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    coef_enable   = 1'b0;
    sample_enable = 1'b0;
    data_in       = 8'd0;
    last_out      = 16'd0;
    do_reset();

    // Basic load and two samples: 4, then 4+5.
    load(8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'd1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'd1, 1'b1, 1'b0);
    chk("tp_second_out", 32'(data_out), 32'd9);

    // Reload clears history but keeps data_out; then 20, 32, 45, 59.
    load(8'd10, 8'd11, 8'd12, 8'd13, 8'd14);
    chk("reload_keeps_out", 32'(data_out), 32'd9);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'd2, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'd1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'd1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'd1, 1'b1, 1'b0);
    chk("tp_reload_last", 32'(data_out), 32'd59);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

    // Both enables in READY: error, data_out frozen, samples ignored.
    step(1'b1, 1'b1, 8'd3, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'd7, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'd7, 1'b0, 1'b1);
    do_reset();

    // Sample before any coefficient load.
    step(1'b0, 1'b1, 8'd9, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'd9, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    do_reset();

    // Partial load of three coefficients.
    step(1'b1, 1'b0, 8'd1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'd2, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'd3, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    do_reset();

    // Sixth coefficient.
    load(8'd1, 8'd2, 8'd3, 8'd4, 8'd5);
    step(1'b1, 1'b0, 8'd6, 1'b0, 1'b1);
    do_reset();

    // Full-scale: first sample on the load-complete edge, five samples of 255.
    load(8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'd255, 1'b1, 1'b0);
    chk("full_scale_fifth", 32'(data_out), 32'((5 * 65025) % 65536));
    // Mid-stream reset while out_enable is high.
    do_reset();

    // After reset a full load is needed again.
    step(1'b0, 1'b1, 8'd1, 1'b0, 1'b1);
    do_reset();
    step(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
